// File: rtl/cflog_writer_pkg.sv
// Shared definitions for the control-flow log writer: FSM encoding, default
// log geometry and entry layout constants.
package cflog_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_DST = 3'd1,
    ST_WR_SRC   = 3'd2,
    ST_WR_DST   = 3'd3,
    ST_FULL     = 3'd4
  } cflog_state_e;

  localparam logic [15:0] CFLOG_LOG_BASE_DEF = 16'hA100;
  localparam logic [15:0] CFLOG_LOG_SIZE_DEF = 16'h0100;
  localparam int unsigned CFLOG_ENTRY_WORDS  = 2;
  localparam logic [15:0] CFLOG_WORD_BYTES   = 16'd2;
  localparam logic [15:0] CFLOG_ENTRY_BYTES  = 16'd4;

  function automatic logic cflog_in_region(input logic [15:0] addr,
                                           input logic [15:0] lo,
                                           input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/cflog_edge_det.sv
// Rising-edge detector: turns a multi-cycle branch_detect level into a
// single-cycle event pulse.
module cflog_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  // Registered copy of the level, used to spot the low-to-high transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/cflog_writer.sv
// Control-flow log writer: records (source PC, destination PC) pairs into the
// CF-Log region. Optional macro CFLOG_ER_FILTER_EN restricts logging to [ER_min, ER_max].
module cflog_writer
  import cflog_writer_pkg::*;
#(
  parameter logic [15:0] LOG_BASE = CFLOG_LOG_BASE_DEF,
  parameter logic [15:0] LOG_SIZE = CFLOG_LOG_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        inst_fetch,
  input  logic        branch_detect,
  input  logic [15:0] ER_min,
  input  logic [15:0] ER_max,
  input  logic        log_clr,
  output logic        log_wr_en,
  output logic [15:0] log_wr_addr,
  output logic [15:0] log_wr_data,
  output logic [15:0] log_ptr,
  output logic        log_full,
  output logic        log_ovf,
  output logic        flush_req
);

  cflog_state_e state_q, state_d;
  logic [15:0]  src_q, src_d;
  logic [15:0]  dst_q, dst_d;
  logic [15:0]  ptr_q, ptr_d;
  logic [15:0]  addr_q, addr_d;
  logic [15:0]  data_q, data_d;
  logic         wr_en_q, wr_en_d;
  logic         full_q, full_d;
  logic         flush_q, flush_d;
  logic         ovf_q, ovf_d;
  logic         det_s;
  logic         accept_s;

  cflog_edge_det u_edge_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (branch_detect),
    .rise_o  (det_s)
  );

`ifdef CFLOG_ER_FILTER_EN
  assign accept_s = det_s & cflog_in_region(pc, ER_min, ER_max);
`else
  logic unused_er_s;
  assign unused_er_s = ^{ER_min, ER_max};
  assign accept_s    = det_s;
`endif

  // Next-state, pointer and registered-output computation.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    full_d  = full_q;
    flush_d = flush_q;
    ovf_d   = ovf_q;
    if (log_clr) begin
      // Clear wins over everything, including a coincident det.
      state_d = ST_IDLE;
      ptr_d   = 16'd0;
      full_d  = 1'b0;
      flush_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            src_d   = pc;
            state_d = ST_WAIT_DST;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_DST: begin
          if (det_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          if (inst_fetch) begin
            dst_d   = pc;
            state_d = ST_WR_SRC;
            wr_en_d = 1'b1;
            addr_d  = LOG_BASE + ptr_q;
            data_d  = src_q;
          end else begin
            state_d = ST_WAIT_DST;
          end
        end
        ST_WR_SRC: begin
          if (det_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          ptr_d   = ptr_q + CFLOG_WORD_BYTES;
          state_d = ST_WR_DST;
          wr_en_d = 1'b1;
          addr_d  = LOG_BASE + ptr_d;
          data_d  = dst_q;
        end
        ST_WR_DST: begin
          if (det_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          ptr_d = ptr_q + CFLOG_WORD_BYTES;
          if (ptr_d == LOG_SIZE) begin
            state_d = ST_FULL;
            full_d  = 1'b1;
            flush_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FULL: begin
          if (det_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          full_d  = 1'b1;
          flush_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= 16'd0;
      dst_q   <= 16'd0;
      ptr_q   <= 16'd0;
      addr_q  <= 16'd0;
      data_q  <= 16'd0;
      wr_en_q <= 1'b0;
      full_q  <= 1'b0;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      full_q  <= full_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
    end
  end

  assign log_wr_en   = wr_en_q;
  assign log_wr_addr = addr_q;
  assign log_wr_data = data_q;
  assign log_ptr     = ptr_q;
  assign log_full    = full_q;
  assign log_ovf     = ovf_q;
  assign flush_req   = flush_q;

endmodule

// File: tb/tb_cflog_writer.sv
// Scoreboard bench for cflog_writer with an 8-byte log (two entries).
module tb_cflog_writer;

  localparam logic [15:0] TB_BASE = 16'hA100;
  localparam logic [15:0] TB_SIZE = 16'h0008;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        inst_fetch;
  logic        branch_detect;
  logic [15:0] ER_min;
  logic [15:0] ER_max;
  logic        log_clr;
  logic        log_wr_en;
  logic [15:0] log_wr_addr;
  logic [15:0] log_wr_data;
  logic [15:0] log_ptr;
  logic        log_full;
  logic        log_ovf;
  logic        flush_req;

  int n_checks = 0;
  int n_fails  = 0;
  int wr_cnt   = 0;
  logic [31:0] exp_q[$];

  cflog_writer #(.LOG_BASE(TB_BASE), .LOG_SIZE(TB_SIZE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .inst_fetch    (inst_fetch),
    .branch_detect (branch_detect),
    .ER_min        (ER_min),
    .ER_max        (ER_max),
    .log_clr       (log_clr),
    .log_wr_en     (log_wr_en),
    .log_wr_addr   (log_wr_addr),
    .log_wr_data   (log_wr_data),
    .log_ptr       (log_ptr),
    .log_full      (log_full),
    .log_ovf       (log_ovf),
    .flush_req     (flush_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && log_wr_en) begin
      wr_cnt++;
      check("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        check("wr_addr_data", {log_wr_addr, log_wr_data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_det(input logic [15:0] p, input int hi);
    pc = p;
    branch_detect = 1'b1;
    repeat (hi) tick();
    branch_detect = 1'b0;
  endtask

  task automatic send_fetch(input logic [15:0] p);
    pc = p;
    inst_fetch = 1'b1;
    tick();
    inst_fetch = 1'b0;
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc = 16'd0; inst_fetch = 1'b0; branch_detect = 1'b0;
    ER_min = 16'hE000; ER_max = 16'hE0FF; log_clr = 1'b0;
    tick(); tick();
    check("rst_outputs", {log_wr_en, log_full, log_ovf, flush_req, 28'd0}, 32'd0);
    check("rst_addr_data", {log_wr_addr, log_wr_data}, 32'd0);
    check("rst_ptr", {16'd0, log_ptr}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single entry, branch_detect held three cycles, fetch two cycles later.
    exp_q.push_back({16'hA100, 16'hE010});
    exp_q.push_back({16'hA102, 16'hE200});
    send_det(16'hE010, 3);
    tick();
    send_fetch(16'hE200);
    repeat (3) tick();
    check("single_ptr", {16'd0, log_ptr}, 32'd4);
    check("single_wr_cnt", wr_cnt, 32'd2);
    check("single_not_full", {31'd0, log_full}, 32'd0);

    // Second entry fills the log.
    exp_q.push_back({16'hA104, 16'hE020});
    exp_q.push_back({16'hA106, 16'hE220});
    send_det(16'hE020, 1);
    send_fetch(16'hE220);
    tick();
    @(negedge clk);
    check("fill_full_during_write", {30'd0, log_full, flush_req}, 32'd0);
    tick();
    check("fill_full_after", {30'd0, log_full, flush_req}, 32'd3);
    check("fill_ptr", {16'd0, log_ptr}, 32'd8);
    send_det(16'hE0A0, 1);
    tick();
    send_fetch(16'hE2A0);
    repeat (2) tick();
    check("full_ovf", {31'd0, log_ovf}, 32'd1);
    check("full_wr_cnt", wr_cnt, 32'd4);
    check("full_hold", {30'd0, log_full, flush_req}, 32'd3);
    clear_log();
    check("clr_state", {16'd0, log_ptr}, 32'd0);
    check("clr_flags", {29'd0, log_full, flush_req, log_ovf}, 32'd0);

    // Collision: second det while waiting for the destination.
    exp_q.push_back({16'hA100, 16'hE030});
    exp_q.push_back({16'hA102, 16'hE330});
    send_det(16'hE030, 1);
    tick();
    send_det(16'hE0B0, 1);
    send_fetch(16'hE330);
    repeat (3) tick();
    check("coll_ovf", {31'd0, log_ovf}, 32'd1);
    check("coll_ptr", {16'd0, log_ptr}, 32'd4);
    clear_log();

    // Clear during the source write aborts the entry.
    exp_q.push_back({16'hA100, 16'hE040});
    send_det(16'hE040, 1);
    tick();
    send_det(16'hE0C0, 1);
    send_fetch(16'hE440);
    @(negedge clk);
    check("mid_ovf_before_clr", {31'd0, log_ovf}, 32'd1);
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
    @(negedge clk);
    check("mid_clr_wr_en", {31'd0, log_wr_en}, 32'd0);
    check("mid_clr_ptr_ovf", {15'd0, log_ovf, log_ptr}, 32'd0);
    repeat (2) tick();
    check("mid_clr_wr_cnt", wr_cnt, 32'd7);

    // Clear coincident with det drops the event without overflow.
    pc = 16'hE050;
    branch_detect = 1'b1;
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
    branch_detect = 1'b0;
    tick();
    send_fetch(16'hE550);
    repeat (3) tick();
    check("clr_det_dropped", wr_cnt, 32'd7);
    check("clr_det_ovf_ptr", {15'd0, log_ovf, log_ptr}, 32'd0);

    // Asynchronous reset in the middle of the destination write.
    exp_q.push_back({16'hA100, 16'hE060});
    send_det(16'hE060, 1);
    send_fetch(16'hE660);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {log_wr_en, log_full, log_ovf, flush_req, 28'd0}, 32'd0);
    check("async_rst_addr_data", {log_wr_addr, log_wr_data}, 32'd0);
    check("async_rst_ptr", {16'd0, log_ptr}, 32'd0);
    tick();
    rst_n = 1'b1;
    exp_q.push_back({16'hA100, 16'hE070});
    exp_q.push_back({16'hA102, 16'hE770});
    send_det(16'hE070, 1);
    send_fetch(16'hE770);
    repeat (3) tick();
    check("post_rst_ptr", {16'd0, log_ptr}, 32'd4);
    clear_log();

`ifdef CFLOG_ER_FILTER_EN
    send_det(16'hF000, 1);
    tick();
    send_fetch(16'hF100);
    repeat (3) tick();
    check("er_out_ovf_ptr", {15'd0, log_ovf, log_ptr}, 32'd0);
    exp_q.push_back({16'hA100, 16'hE080});
    exp_q.push_back({16'hA102, 16'hE880});
    send_det(16'hE080, 1);
    send_fetch(16'hE880);
    repeat (3) tick();
    check("er_in_ptr", {16'd0, log_ptr}, 32'd4);
`else
    exp_q.push_back({16'hA100, 16'hF000});
    exp_q.push_back({16'hA102, 16'hF100});
    send_det(16'hF000, 1);
    tick();
    send_fetch(16'hF100);
    repeat (3) tick();
    check("nofilter_ptr", {16'd0, log_ptr}, 32'd4);
`endif

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cflog_writer.md
Name: cflog_writer

Overview:
- Downstream of the branch monitor. Consumes its branch_detect pulse and records one control-flow log entry per event.
- An entry is a (source PC, destination PC) pair, written as two 16-bit words into the CF-Log region of TCB memory.
- Tracks the log fill pointer and raises flush_req when the log is full, so the attestation NMI path can report and clear it.

Parameters:
- LOG_BASE, 16'hA100: byte address of the first CF-Log word.
- LOG_SIZE, 16'h0100: log capacity in bytes. Must be nonzero and a multiple of 4.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pc  input  16  current program counter
- inst_fetch  input  1  one-cycle strobe when a new instruction is fetched; pc is valid as the fetch address
- branch_detect  input  1  branch-monitor detect output; may stay high for several cycles
- ER_min  input  16  executable-region lower bound, inclusive
- ER_max  input  16  executable-region upper bound, inclusive
- log_clr  input  1  clear log after flush or attestation
- log_wr_en  output  1  memory write strobe, one cycle per word
- log_wr_addr  output  16  byte address of the write
- log_wr_data  output  16  write data
- log_ptr  output  16  bytes currently used in the log
- log_full  output  1  log has reached LOG_SIZE
- log_ovf  output  1  sticky: an event was dropped
- flush_req  output  1  request to report and flush the log

Behaviour:
- Reset (rst_n low, async): state IDLE; log_ptr=0; all other outputs 0; src/dst registers 0; edge register 0.
- Event detect: det = branch_detect & ~branch_detect_q, where branch_detect_q is a registered copy. A multi-cycle high level counts as one event.
- All outputs are registered. log_wr_addr = LOG_BASE + log_ptr, 16-bit, wraps modulo 2^16.
- FSM states: IDLE, WAIT_DST, WR_SRC, WR_DST, FULL.
  - IDLE: on det, capture src_q <= pc and go to WAIT_DST. An inst_fetch in the same cycle as det is ignored.
  - WAIT_DST: on inst_fetch, capture dst_q <= pc and go to WR_SRC.
  - WR_SRC: log_wr_en=1, data=src_q; log_ptr += 2; go to WR_DST.
  - WR_DST: log_wr_en=1, data=dst_q; log_ptr += 2. If the new log_ptr == LOG_SIZE: go to FULL and set log_full=1, flush_req=1. Otherwise go to IDLE.
  - FULL: hold log_full and flush_req high. det events set log_ovf and are dropped. Stay until log_clr.
- Latency: det at cycle T, fetch at T+k (k≥1) → src word written at T+k+1, dst word at T+k+2.
- Busy collision: det in WAIT_DST, WR_SRC or WR_DST sets log_ovf (sticky). The new event is dropped; the in-flight entry completes.
- log_clr, any state: next cycle state IDLE, log_ptr=0, log_full=0, flush_req=0, log_ovf=0; any in-flight entry is aborted with no further writes. log_clr has priority over a det in the same cycle, and that det is dropped without setting log_ovf.
- log_ptr never exceeds LOG_SIZE. Entries are never split across a clear.

Optional Feature:
- Macro: CFLOG_ER_FILTER_EN.
- Defined: in IDLE, det is accepted only if ER_min ≤ pc ≤ ER_max (unsigned). Out-of-region events are silently ignored and do not set log_ovf.
- Undefined: ER_min and ER_max are unused and every det is logged.

Decomposition:
- Shared package: FSM state encoding (3-bit); default LOG_BASE/LOG_SIZE constants; the entry word count (2) and ENTRY_BYTES=4.
- One natural sub-module, cflog_edge_det: the rising-edge detector on branch_detect with async active-low reset.

Test Plan:
- Single entry: pc=16'hE010, branch_detect high 3 cycles; fetch 2 cycles later with pc=16'hE200 → exactly two writes: (A100, E010) then (A102, E200); log_ptr=4; log_wr_en high 2 cycles total.
- Fill: LOG_SIZE=8, two entries → second dst write at A106; log_ptr=8; log_full=flush_req=1 in the cycle after that write; a third det → log_ovf=1 and no write.
- Collision: det, then a second det while in WAIT_DST → first entry written intact; log_ovf=1; log_ptr=4.
- Clear mid-entry: det, fetch, log_clr asserted during WR_SRC → at most one write; next cycle log_ptr=0, state IDLE, log_ovf=0; log_clr together with det → event dropped.
- Async reset: rst_n low mid-WR_DST with no clk edge → all outputs 0 immediately; after release, a fresh event logs at A100.
- With CFLOG_ER_FILTER_EN: ER=[E000,E0FF]; det at pc=F000 → no write and log_ovf=0; det at pc=E080 → logged normally.
